// File: rtl/chip8_pkg.sv
// Shared constants, FSM encoding and hex font table for the CHIP-8 memory block.
// The INIT state and font table exist only when CHIP8_FONT_PRELOAD_EN is defined.
package chip8_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int FONT_BYTES = 80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_FH   = 3'd2,
    ST_FL   = 3'd3
`ifdef CHIP8_FONT_PRELOAD_EN
    ,
    ST_INIT = 3'd4
`endif
  } state_e;

`ifdef CHIP8_FONT_PRELOAD_EN
  // Sprites 0..F, five rows each, MSB is the leftmost pixel
  localparam logic [7:0] FONT_ROM [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    if (idx < 7'd80) begin
      return FONT_ROM[idx];
    end else begin
      return 8'h00;
    end
  endfunction
`endif

endpackage

// File: rtl/chip8_ram_sp.sv
// Single-port synchronous RAM: write at the clock edge, registered read data one cycle later.
// Contents are never reset.
module chip8_ram_sp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage array with read-before-write registered output
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/chip8_mem.sv
// CHIP-8 4 KiB main memory: serialises execute writes/reads and 16-bit opcode fetches onto one RAM port.
// Define CHIP8_FONT_PRELOAD_EN to load the hex font at FONT_BASE after every reset.
module chip8_mem
  import chip8_pkg::*;
#(
  parameter int                ADDR_W    = chip8_pkg::ADDR_W,
  parameter int                DATA_W    = chip8_pkg::DATA_W,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] FONT_BASE = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_mem_w_en,
  input  logic [ADDR_W-1:0]   i_mem_w_addr,
  input  logic [DATA_W-1:0]   i_mem_w_data,
  input  logic                i_mem_r_en,
  input  logic [ADDR_W-1:0]   i_mem_r_addr,
  output logic [DATA_W-1:0]   o_mem_r_data,
  output logic                o_mem_r_valid,
  input  logic                i_fetch_en,
  input  logic [ADDR_W-1:0]   i_fetch_addr,
  output logic [2*DATA_W-1:0] o_fetch_data,
  output logic                o_fetch_valid,
  output logic                o_busy
);

  if ((MEM_DEPTH != (32'd1 << ADDR_W)) || ((int'(FONT_BASE) + FONT_BYTES) > MEM_DEPTH)) begin : g_bad_cfg
    $error("chip8_mem: MEM_DEPTH must equal 2**ADDR_W and the font must fit in memory");
  end

`ifdef CHIP8_FONT_PRELOAD_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e              state_r;
  state_e              state_s;
  logic                fetch_acc_s;
  logic                ram_we_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_s;
  logic [DATA_W-1:0]   ram_rdata_s;
  logic [ADDR_W-1:0]   fetch_addr_r;
  logic [DATA_W-1:0]   fetch_hi_r;
  logic [DATA_W-1:0]   r_data_r;
  logic                r_valid_r;
  logic [2*DATA_W-1:0] f_data_r;
  logic                f_valid_r;
  logic                busy_r;
`ifdef CHIP8_FONT_PRELOAD_EN
  logic [6:0]          init_cnt_r;
`endif

  chip8_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Arbitration (write > read > fetch) and RAM port steering
  always_comb begin
    state_s     = state_r;
    fetch_acc_s = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = fetch_addr_r;
    ram_wdata_s = i_mem_w_data;
    case (state_r)
      ST_IDLE: begin
        if (i_mem_w_en) begin
          ram_we_s   = 1'b1;
          ram_addr_s = i_mem_w_addr;
        end else if (i_mem_r_en) begin
          ram_addr_s = i_mem_r_addr;
          state_s    = ST_RD;
        end else if (i_fetch_en) begin
          ram_addr_s  = i_fetch_addr;
          fetch_acc_s = 1'b1;
          state_s     = ST_FH;
        end else begin
          ram_addr_s = fetch_addr_r;
        end
      end
      ST_RD: begin
        state_s = ST_IDLE;
      end
      ST_FH: begin
        // Low byte lives at the next address, wrapping at the top of memory
        ram_addr_s = fetch_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_s    = ST_FL;
      end
      ST_FL: begin
        state_s = ST_IDLE;
      end
`ifdef CHIP8_FONT_PRELOAD_EN
      ST_INIT: begin
        if (init_cnt_r == 7'd80) begin
          state_s = ST_IDLE;
        end else begin
          ram_we_s    = 1'b1;
          ram_addr_s  = FONT_BASE + ADDR_W'(init_cnt_r);
          ram_wdata_s = font_byte(init_cnt_r);
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, fetch bookkeeping and registered responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= RESET_STATE;
      fetch_addr_r <= '0;
      fetch_hi_r   <= '0;
      r_data_r     <= '0;
      r_valid_r    <= 1'b0;
      f_data_r     <= '0;
      f_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != ST_IDLE);
      r_valid_r <= (state_r == ST_RD);
      f_valid_r <= (state_r == ST_FL);
      if (fetch_acc_s) begin
        fetch_addr_r <= i_fetch_addr;
      end
      if (state_r == ST_FH) begin
        fetch_hi_r <= ram_rdata_s;
      end
      if (state_r == ST_RD) begin
        r_data_r <= ram_rdata_s;
      end
      if (state_r == ST_FL) begin
        f_data_r <= {fetch_hi_r, ram_rdata_s};
      end
    end
  end

`ifdef CHIP8_FONT_PRELOAD_EN
  // Font byte index; restarts at zero on every reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt_r <= 7'd0;
    end else if ((state_r == ST_INIT) && (init_cnt_r != 7'd80)) begin
      init_cnt_r <= init_cnt_r + 7'd1;
    end
  end
`endif

  assign o_mem_r_data  = r_data_r;
  assign o_mem_r_valid = r_valid_r;
  assign o_fetch_data  = f_data_r;
  assign o_fetch_valid = f_valid_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_chip8_mem.sv
// Self-checking bench for chip8_mem: directed vector table, reset/abort sequence and
// randomized request mixes checked against a byte-array memory model.
module tb_chip8_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_w_en;
  logic [11:0] i_mem_w_addr;
  logic [7:0]  i_mem_w_data;
  logic        i_mem_r_en;
  logic [11:0] i_mem_r_addr;
  logic [7:0]  o_mem_r_data;
  logic        o_mem_r_valid;
  logic        i_fetch_en;
  logic [11:0] i_fetch_addr;
  logic [15:0] o_fetch_data;
  logic        o_fetch_valid;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [4096];

  typedef struct {
    logic        w;
    logic [11:0] wa;
    logic [7:0]  wd;
    logic        r;
    logic [11:0] ra;
    logic        f;
    logic [11:0] fa;
    logic [7:0]  er;
    logic [15:0] ef;
  } vec_t;

  vec_t tbl [13];

  chip8_mem dut (
    .clk           (clk),
    .rst           (rst),
    .i_mem_w_en    (i_mem_w_en),
    .i_mem_w_addr  (i_mem_w_addr),
    .i_mem_w_data  (i_mem_w_data),
    .i_mem_r_en    (i_mem_r_en),
    .i_mem_r_addr  (i_mem_r_addr),
    .o_mem_r_data  (o_mem_r_data),
    .o_mem_r_valid (o_mem_r_valid),
    .i_fetch_en    (i_fetch_en),
    .i_fetch_addr  (i_fetch_addr),
    .o_fetch_data  (o_fetch_data),
    .o_fetch_valid (o_fetch_valid),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raise the requested lines together and check every cycle against the expected schedule:
  // a write takes one edge, a read answers two cycles after it starts, a fetch three.
  task automatic issue(input logic w, input logic [11:0] wa, input logic [7:0] wd,
                       input logic r, input logic [11:0] ra,
                       input logic f, input logic [11:0] fa,
                       input logic [7:0] er, input logic [15:0] ef);
    int t, rv_c, fv_c, last, bc;
    bit busy_exp;
    bc = 0;
    while (o_busy === 1'b1 && bc < 200) begin
      @(negedge clk);
      bc++;
    end
    if (o_busy !== 1'b0) begin
      check("idle_wait_timeout", o_busy, 1'b0);
      return;
    end
    t = w ? 1 : 0;
    rv_c = -10;
    fv_c = -10;
    if (r) begin
      rv_c = t + 2;
      t = t + 2;
    end
    if (f) fv_c = t + 3;
    last = (f ? fv_c : (r ? rv_c : 1)) + 1;
    i_mem_w_en = w;   i_mem_w_addr = wa; i_mem_w_data = wd;
    i_mem_r_en = r;   i_mem_r_addr = ra;
    i_fetch_en = f;   i_fetch_addr = fa;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) i_mem_w_en = 1'b0;
      busy_exp = (r && c == rv_c - 1) || (f && (c == fv_c - 1 || c == fv_c - 2));
      check("busy", o_busy, busy_exp);
      check("r_valid", o_mem_r_valid, (c == rv_c));
      check("f_valid", o_fetch_valid, (c == fv_c));
      if (c == rv_c) begin
        check("r_data", o_mem_r_data, er);
        i_mem_r_en = 1'b0;
      end
      if (c == fv_c) begin
        check("f_data", o_fetch_data, ef);
        i_fetch_en = 1'b0;
      end
    end
  endtask

  initial begin
    logic        w, r, f;
    logic [11:0] wa, ra, fa, base, a;
    logic [7:0]  wd, er;
    logic [15:0] ef;

    tbl[0]  = '{1'b1, 12'h200, 8'hAB, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[1]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h200, 1'b0, 12'h000, 8'hAB, 16'h0000};
    tbl[2]  = '{1'b1, 12'h300, 8'h12, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[3]  = '{1'b1, 12'h301, 8'h34, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[4]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 12'h300, 8'h00, 16'h1234};
    tbl[5]  = '{1'b1, 12'hFFF, 8'h56, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[6]  = '{1'b1, 12'h000, 8'h78, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[7]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 12'hFFF, 8'h00, 16'h5678};
    tbl[8]  = '{1'b1, 12'h302, 8'h5A, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[9]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 12'h301, 8'h00, 16'h345A};
    tbl[10] = '{1'b1, 12'h201, 8'hCD, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 16'h0000};
    tbl[11] = '{1'b1, 12'h400, 8'h9C, 1'b1, 12'h400, 1'b1, 12'h200, 8'h9C, 16'hABCD};
    tbl[12] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h300, 1'b0, 12'h000, 8'h12, 16'h0000};

    rst = 1'b0;
    i_mem_w_en = 1'b0; i_mem_w_addr = 12'h000; i_mem_w_data = 8'h00;
    i_mem_r_en = 1'b0; i_mem_r_addr = 12'h000;
    i_fetch_en = 1'b0; i_fetch_addr = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_r_valid", o_mem_r_valid, 1'b0);
    check("rst_f_valid", o_fetch_valid, 1'b0);
    check("rst_r_data", o_mem_r_data, 8'h00);
    check("rst_f_data", o_fetch_data, 16'h0000);
    rst = 1'b1;

`ifdef CHIP8_FONT_PRELOAD_EN
    begin
      int  busy_cnt;
      bit  init_done, seen;
      logic [7:0] got;
      busy_cnt = 0; init_done = 1'b0; seen = 1'b0; got = 8'h00;
      i_mem_r_addr = 12'h04F;
      i_mem_r_en   = 1'b1;
      for (int c = 0; c < 300 && !seen; c++) begin
        @(negedge clk);
        if (!init_done && o_busy === 1'b1) busy_cnt++;
        else init_done = 1'b1;
        if (o_mem_r_valid === 1'b1) begin
          seen = 1'b1;
          got = o_mem_r_data;
          i_mem_r_en = 1'b0;
        end
      end
      i_mem_r_en = 1'b0;
      check("init_busy_cycles", busy_cnt, 80);
      check("init_read_seen", seen, 1'b1);
      check("font_last_byte", got, 8'h80);
      @(negedge clk);
      issue(1'b0, 12'h000, 8'h00, 1'b1, 12'h000, 1'b0, 12'h000, 8'hF0, 16'h0000);
    end
`endif

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra,
            tbl[i].f, tbl[i].fa, tbl[i].er, tbl[i].ef);
    end

    repeat (3) @(negedge clk);
    check("hold_r_data", o_mem_r_data, 8'h12);
    check("hold_f_data", o_fetch_data, 16'hABCD);

    // Reset while the fetch is in its high-byte cycle
    i_fetch_addr = 12'h300;
    i_fetch_en   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_f_valid", o_fetch_valid, 1'b0);
    check("abort_f_data", o_fetch_data, 16'h0000);
    check("abort_r_data", o_mem_r_data, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_valid", o_fetch_valid, 1'b0);
    end
    i_fetch_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b1, 12'h300, 8'h00, 16'h1234);

    // Back-to-back writes fill a block that straddles the top of memory
    base = 12'hF80;
    for (int k = 0; k < 256; k++) begin
      a = base + 12'(k);
      wd = 8'($urandom);
      model[a] = wd;
      i_mem_w_en = 1'b1; i_mem_w_addr = a; i_mem_w_data = wd;
      @(negedge clk);
      check("b2b_write_busy", o_busy, 1'b0);
    end
    i_mem_w_en = 1'b0;

    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if (!w && !r && !f) r = 1'b1;
      wa = base + 12'($urandom_range(0, 255));
      wd = 8'($urandom);
      ra = (n % 4 == 0) ? wa : base + 12'($urandom_range(0, 255));
      fa = base + 12'($urandom_range(0, 254));
      if (w) model[wa] = wd;
      er = model[ra];
      ef = {model[fa], model[fa + 12'd1]};
      issue(w, wa, wd, r, ra, f, fa, er, ef);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chip8_mem.md
Name: chip8_mem

Overview:
- Byte-wide 4 KiB CHIP-8 main memory. Responder side of the execute unit's memory interface (mem write/read request lines) plus a 16-bit instruction-fetch port for the fetch stage.
- Serialises all requests through a small FSM over a single-port synchronous RAM, and reports completion with valid pulses and a busy flag.

Parameters:
ADDR_W, 12, byte address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, data byte width.
MEM_DEPTH, 4096, number of bytes; must equal 2^ADDR_W.
FONT_BASE, 12'h000, base address of the hex font sprites; used only when the optional feature is enabled.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
i_mem_w_en  in  1  execute write request (level, held until accepted).
i_mem_w_addr  in  ADDR_W  write byte address.
i_mem_w_data  in  DATA_W  write data.
i_mem_r_en  in  1  execute read request (level, held until o_mem_r_valid).
i_mem_r_addr  in  ADDR_W  read byte address.
o_mem_r_data  out  DATA_W  read data, qualified by o_mem_r_valid.
o_mem_r_valid  out  1  one-cycle read-complete pulse.
i_fetch_en  in  1  instruction fetch request (level, held until o_fetch_valid).
i_fetch_addr  in  ADDR_W  opcode address (high byte).
o_fetch_data  out  16  opcode {mem[a], mem[a+1]}, qualified by o_fetch_valid.
o_fetch_valid  out  1  one-cycle fetch-complete pulse.
o_busy  out  1  high when no new request can be accepted this cycle.

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE (or INIT with the feature); all outputs are 0. RAM contents are not cleared. Reset mid-operation aborts the request with no valid pulse, and a write in flight may be lost.
- States: IDLE, RD, FH (fetch high byte), FL (fetch low byte), and INIT (feature only).
- Acceptance:
  - A request is accepted only on a rising edge where the FSM is in IDLE.
  - Arbitration priority is write > read > fetch. Losing requests stay pending, because the requester holds its en line.
  - o_busy = (state != IDLE).
- Write: RAM is written at the accepting edge. The FSM stays in IDLE. No response is given; the requester may drop w_en the next cycle. Back-to-back writes run at one per cycle.
- Read:
  - Accepted at edge N, the FSM goes IDLE->RD.
  - At edge N+1, o_mem_r_data is registered and o_mem_r_valid is high for exactly one cycle; the FSM returns to IDLE.
  - The requester must drop r_en in the valid cycle, otherwise a second read is issued.
- Fetch:
  - Accepted at edge N, the FSM goes IDLE->FH, reading a. At N+1 it goes FH->FL, reading (a+1) mod 2^ADDR_W, so 0xFFF wraps to 0x000.
  - At N+2, o_fetch_data and o_fetch_valid pulse for one cycle and the FSM returns to IDLE.
  - Odd addresses are legal.
- Simultaneous requests:
  - Write and read to the same address in one cycle: the write is accepted first; the read is served next and returns the new data.
  - A write pending during a fetch is accepted after the fetch completes.
- Output data holds its last value between valid pulses.

Optional Feature:
- Macro: CHIP8_FONT_PRELOAD_EN.
- Defined:
  - After reset deasserts, the FSM enters INIT and writes the 80-byte hex font (0-F, 5 bytes each) to FONT_BASE..FONT_BASE+79, one byte per cycle.
  - o_busy stays high for exactly 80 cycles. All requests wait (not dropped).
  - Reset during INIT restarts the load at byte 0.
- Undefined: no INIT state; IDLE immediately after reset; memory contents start undefined.

Decomposition:
- Shared package chip8_pkg:
  - ADDR_W/DATA_W constants.
  - FSM state encoding.
  - FONT_BYTES=80.
  - The 80-entry font constant table.
- One sub-module, chip8_ram_sp: single-port synchronous RAM (we, addr, wdata, rdata, 1-cycle read). The FSM and arbitration live in chip8_mem.

Test Plan:
1. Write 0xAB @0x200, then read 0x200 -> o_mem_r_valid one cycle after acceptance, o_mem_r_data=0xAB, o_busy high exactly 1 cycle.
2. Write 0x12 @0x300 and 0x34 @0x301, then fetch 0x300 -> o_fetch_valid 2 cycles after acceptance, o_fetch_data=0x1234.
3. Write 0x56 @0xFFF and 0x78 @0x000, then fetch 0xFFF -> o_fetch_data=0x5678 (wrap).
4. Same cycle: w_en (0x400<-0x9C), r_en @0x400, fetch_en @0x200 -> write first, read returns 0x9C, fetch served last; each valid pulses once.
5. Assert rst low while in FH -> outputs 0 immediately, no o_fetch_valid; a repeated fetch after release completes normally.
6. With CHIP8_FONT_PRELOAD_EN: release reset -> o_busy high 80 cycles; read FONT_BASE -> 0xF0, FONT_BASE+79 -> 0x80; a read requested during INIT completes after INIT.
